// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  // addi x0,x0,0 -- the canonical bubble
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  // Instruction fetches are word aligned; drop the low two address bits.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction ROM port, IF/ID outputs.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc4;
  logic            if_valid;

  // Fetch unit side
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_pc, if_inst, if_pc4, if_valid
  );

  // Pipeline / ROM side
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_pc, if_inst, if_pc4, if_valid
  );
endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter: redirect load beats stall hold, otherwise step by one word.
module if_fetch_unit_pc_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_q
);

  logic [XLEN-1:0] pc_d;

  // Next-PC select; the +4 wraps naturally at the top of the address space.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (redirect_valid)
      pc_d = pc_align(redirect_pc);
    else if (stall)
      pc_d = pc_q;
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC owner, sync-ROM addressing, stall hold buffer, IF/ID outputs.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.master bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] f2_pc_q;
  logic            f2_valid_q;
  logic [XLEN-1:0] hold_q;
  logic            hold_valid_q;

  if_fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (bus.stall),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .pc_q           (pc_q)
  );

  // F2 stage tracks which PC the ROM is returning; a redirect kills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f2_pc_q    <= '0;
      f2_valid_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      f2_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      f2_pc_q    <= pc_q;
      f2_valid_q <= 1'b1;
    end
  end

  // Capture the ROM word on the first stall cycle so the output instruction
  // stays put while the ROM keeps being read at the (held) next address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      hold_valid_q <= 1'b0;
    end else if (bus.stall) begin
      if (!hold_valid_q) begin
        hold_q       <= bus.imem_rdata;
        hold_valid_q <= 1'b1;
      end
    end else begin
      hold_valid_q <= 1'b0;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = f2_pc_q;
  assign bus.if_pc4    = f2_pc_q + XLEN'(4);
  assign bus.if_valid  = f2_valid_q;
  assign bus.if_inst   = !f2_valid_q  ? NOP_INST :
                         hold_valid_q ? hold_q   : bus.imem_rdata;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle ROM holding ROM[i] = i*16.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: word index i holds i*16, i.e. byte address * 4.
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr << 2;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  bus.imem_addr, 32'h0);
    chk({tag, "_pc"},    bus.if_pc, 32'h0);
    chk({tag, "_pc4"},   bus.if_pc4, 32'h4);
    chk({tag, "_inst"},  bus.if_inst, NOP);
    chk({tag, "_valid"}, {31'b0, bus.if_valid}, 32'h0);
  endtask

  // Drive one cycle of inputs, queue what the IF/ID outputs must show after
  // the edge, then pop and compare.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rp,
                       input logic ev, input logic [31:0] epc);
    exp_t e;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    e.valid = ev;
    e.pc    = epc;
    e.inst  = ev ? (epc << 2) : NOP;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    e = sbq.pop_front();
    chk("valid", {31'b0, bus.if_valid}, {31'b0, e.valid});
    chk("inst", bus.if_inst, e.inst);
    if (e.valid) begin
      chk("pc", bus.if_pc, e.pc);
      chk("pc4", bus.if_pc4, e.pc + 32'd4);
    end
  endtask

  initial begin
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    // 1: straight-line fetch from RESET_PC
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h4);
    cycle(0, 0, 0, 1, 32'h8);

    // 2: three stall cycles at if_pc=8; ROM address held at 12
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 32'h8);
      chk("addr_stall", bus.imem_addr, 32'hC);
    end
    cycle(0, 0, 0, 1, 32'hC);
    cycle(0, 0, 0, 1, 32'h10);

    // 3: redirect to 0x100 -> one bubble then target stream
    cycle(0, 1, 32'h100, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h100);
    cycle(0, 0, 0, 1, 32'h104);

    // 4: redirect with stall, unaligned target aligned down to 0x200
    cycle(1, 1, 32'h203, 0, 32'h0);
    chk("addr_align", bus.imem_addr, 32'h200);
    cycle(0, 0, 0, 1, 32'h200);
    cycle(0, 0, 0, 1, 32'h204);

    // 5: back-to-back redirects; 0x40 must never become valid
    cycle(0, 1, 32'h40, 0, 32'h0);
    cycle(0, 1, 32'h80, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h80);
    cycle(0, 0, 0, 1, 32'h84);

    // 6: async reset in the middle of a stall, then restart and PC wrap
    cycle(1, 0, 0, 1, 32'h84);
    bus.stall = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h4);
    cycle(0, 1, 32'hFFFF_FFF8, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("pc4_wrap", bus.if_pc4, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
